// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin share of a byte-wide memory between fetch and load/store, little-endian byte beats
module mem_port_arbiter #(
    parameter int AW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req_i,
    input  logic [AW-1:0] if_addr_i,
    output logic          if_ack_o,
    output logic [31:0]   if_rdata_o,
    input  logic          ls_req_i,
    input  logic          ls_we_i,
    input  logic [1:0]    ls_size_i,
    input  logic [AW-1:0] ls_addr_i,
    input  logic [31:0]   ls_wdata_i,
    output logic          ls_ack_o,
    output logic [31:0]   ls_rdata_o,
    output logic [AW-1:0] mem_addr_o,
    output logic          mem_we_o,
    output logic [7:0]    mem_wdata_o,
    input  logic [7:0]    mem_rdata_i
);
    typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

    state_t        state_q, state_d;
    logic          owner_q;
    logic          cur_q;
    logic [AW-1:0] addr_q;
    logic          we_q;
    logic [31:0]   wdata_q;
    logic [1:0]    last_q;
    logic [1:0]    beat_q;
    logic [31:0]   buf_q, buf_d;
    logic [31:0]   if_rdata_q, ls_rdata_q;
    logic          grant_ls;
    logic          start;
    logic          last_beat;

    // owner_q/cur_q: 1 = load/store port, 0 = fetch port
    assign grant_ls   = ls_req_i && (!if_req_i || !owner_q);
    assign start      = state_q == IDLE && (if_req_i || ls_req_i);
    assign last_beat  = beat_q == last_q;
    assign if_rdata_o = if_rdata_q;
    assign ls_rdata_o = ls_rdata_q;

    // state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // next state: IDLE -> XFER on any request, XFER -> DONE after the last beat, DONE -> IDLE
    always_comb begin
        state_d = (state_q == IDLE) ? (start ? XFER : IDLE) :
                  (state_q == XFER) ? (last_beat ? DONE : XFER) : IDLE;
    end

    // memory strobes only during XFER, acks only in DONE
    always_comb begin
        mem_addr_o  = (state_q == XFER) ? addr_q + AW'(beat_q) : '0;
        mem_we_o    = state_q == XFER && we_q;
        mem_wdata_o = (state_q == XFER && we_q) ? wdata_q[8*beat_q +: 8] : 8'h00;
        if_ack_o    = state_q == DONE && !cur_q;
        ls_ack_o    = state_q == DONE && cur_q;
    end

    // read assembly: current beat's byte dropped into its lane
    always_comb begin
        buf_d = buf_q;
        buf_d[8*beat_q +: 8] = mem_rdata_i;
    end

    // grant latching, beat sequencing and read data capture
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q    <= 1'b1;
            cur_q      <= 1'b0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            last_q     <= 2'd0;
            beat_q     <= 2'd0;
            buf_q      <= '0;
            if_rdata_q <= '0;
            ls_rdata_q <= '0;
        end else if (start) begin
            owner_q <= grant_ls;
            cur_q   <= grant_ls;
            addr_q  <= grant_ls ? ls_addr_i : if_addr_i;
            we_q    <= grant_ls && ls_we_i;
            wdata_q <= ls_wdata_i;
            last_q  <= !grant_ls ? 2'd3 : (ls_size_i == 2'd0) ? 2'd0 : (ls_size_i == 2'd1) ? 2'd1 : 2'd3;
            beat_q  <= 2'd0;
            buf_q   <= '0;
        end else if (state_q == XFER) begin
            beat_q <= beat_q + 2'd1;
            buf_q  <= buf_d;
            if (last_beat && !we_q) begin
                if (cur_q) ls_rdata_q <= buf_d;
                else       if_rdata_q <= buf_d;
            end
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scoreboard bench for mem_port_arbiter with a 256-byte memory model
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        ls_req = 1'b0;
    logic        ls_we = 1'b0;
    logic [1:0]  ls_size = 2'd0;
    logic [31:0] ls_addr = '0;
    logic [31:0] ls_wdata = '0;
    logic        ls_ack;
    logic [31:0] ls_rdata;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    logic [7:0]  mem [256];
    logic        poke_en = 1'b0;
    logic [7:0]  poke_a = '0;
    logic [7:0]  poke_d = '0;

    typedef struct {
        logic        ls;
        logic        chk;
        logic [31:0] data;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] alog[$];
    int          errors = 0;
    int          checks = 0;
    int          lat = 0;
    int          mwe = 0;

    mem_port_arbiter #(.AW(32)) dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_ack_o(if_ack), .if_rdata_o(if_rdata),
        .ls_req_i(ls_req), .ls_we_i(ls_we), .ls_size_i(ls_size), .ls_addr_i(ls_addr),
        .ls_wdata_i(ls_wdata), .ls_ack_o(ls_ack), .ls_rdata_o(ls_rdata),
        .mem_addr_o(mem_addr), .mem_we_o(mem_we), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
    );

    always #5 clk = ~clk;

    // byte memory: combinational read, posedge write, bench preload port has priority
    always @(posedge clk) begin
        if (poke_en) mem[poke_a] <= poke_d;
        else if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
    end
    assign mem_rdata = mem[mem_addr[7:0]];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        poke_en = 1'b1;
        poke_a  = a;
        poke_d  = d;
        @(negedge clk);
        poke_en = 1'b0;
    endtask

    task automatic serve(input int n, input bit hold, input int bound);
        int   got = 0;
        int   cnt = 0;
        exp_t e;
        while (got < n && cnt < bound) begin
            @(negedge clk);
            cnt++;
            lat++;
            mwe += int'(mem_we);
            alog.push_back(mem_addr);
            if (if_ack || ls_ack) begin
                got++;
                if (sb.size() == 0) chk("unexpected ack", {30'd0, if_ack, ls_ack}, 32'd0);
                else begin
                    e = sb.pop_front();
                    chk("ack port", {30'd0, if_ack, ls_ack}, e.ls ? 32'd1 : 32'd2);
                    chk("ack latency", lat, e.lat);
                    if (e.chk) chk("rdata", e.ls ? ls_rdata : if_rdata, e.data);
                    lat = 0;
                    if (!hold) begin
                        if (if_ack) if_req = 1'b0;
                        if (ls_ack) ls_req = 1'b0;
                    end
                end
            end
        end
        chk("ack count", got, n);
    endtask

    task automatic drive_ls(input logic we, input logic [1:0] size, input logic [31:0] addr, input logic [31:0] wdata);
        ls_we    = we;
        ls_size  = size;
        ls_addr  = addr;
        ls_wdata = wdata;
        ls_req   = 1'b1;
        lat      = 0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst if_ack", if_ack, 0);
        chk("rst ls_ack", ls_ack, 0);
        chk("rst mem_we", mem_we, 0);
        chk("rst mem_addr", mem_addr, 0);
        chk("rst mem_wdata", mem_wdata, 0);
        chk("rst if_rdata", if_rdata, 0);
        chk("rst ls_rdata", ls_rdata, 0);
        rst = 1'b0;
        poke(8'h00, 8'h13);
        poke(8'h01, 8'h05);
        poke(8'h02, 8'h10);
        poke(8'h03, 8'h00);
        poke(8'h83, 8'h00);
        poke(8'h50, 8'h00);

        if_addr = 32'h0;
        if_req  = 1'b1;
        lat     = 0;
        sb.push_back('{1'b0, 1'b1, 32'h00100513, 5});
        serve(1, 1'b0, 20);
        @(negedge clk);

        mwe = 0;
        drive_ls(1'b1, 2'd2, 32'h40, 32'hDEADBEEF);
        sb.push_back('{1'b1, 1'b0, 32'h0, 5});
        serve(1, 1'b0, 20);
        chk("store word we cycles", mwe, 4);
        @(negedge clk);
        chk("store word mem", {mem[8'h43], mem[8'h42], mem[8'h41], mem[8'h40]}, 32'hDEADBEEF);

        mwe = 0;
        drive_ls(1'b1, 2'd0, 32'h50, 32'h123456A5);
        sb.push_back('{1'b1, 1'b0, 32'h0, 2});
        serve(1, 1'b0, 20);
        chk("store byte we cycles", mwe, 1);
        @(negedge clk);
        chk("store byte mem", {mem[8'h51], mem[8'h50]}, {24'h0, mem[8'h51], 8'hA5} & 32'h0000FFFF);

        poke(8'h41, 8'hAD);
        poke(8'h42, 8'h80);
        drive_ls(1'b0, 2'd1, 32'h41, 32'hFFFFFFFF);
        sb.push_back('{1'b1, 1'b1, 32'h000080AD, 3});
        serve(1, 1'b0, 20);
        @(negedge clk);

        poke(8'hFE, 8'h11);
        poke(8'hFF, 8'h22);
        alog.delete();
        drive_ls(1'b0, 2'd2, 32'hFFFFFFFE, 32'h0);
        sb.push_back('{1'b1, 1'b1, 32'h05132211, 5});
        serve(1, 1'b0, 20);
        chk("wrap addr0", alog[0], 32'hFFFFFFFE);
        chk("wrap addr1", alog[1], 32'hFFFFFFFF);
        chk("wrap addr2", alog[2], 32'h00000000);
        chk("wrap addr3", alog[3], 32'h00000001);
        @(negedge clk);

        poke(8'h41, 8'hBE);
        poke(8'h42, 8'hAD);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        if_addr = 32'h0;
        if_req  = 1'b1;
        drive_ls(1'b0, 2'd3, 32'h40, 32'h0);
        sb.push_back('{1'b0, 1'b1, 32'h00100513, 5});
        sb.push_back('{1'b1, 1'b1, 32'hDEADBEEF, 6});
        sb.push_back('{1'b0, 1'b1, 32'h00100513, 6});
        sb.push_back('{1'b1, 1'b1, 32'hDEADBEEF, 6});
        serve(4, 1'b1, 60);
        if_req = 1'b0;
        ls_req = 1'b0;
        @(negedge clk);

        poke(8'h80, 8'h00);
        poke(8'h81, 8'h00);
        poke(8'h82, 8'h00);
        drive_ls(1'b1, 2'd2, 32'h80, 32'hCAFEF00D);
        repeat (3) @(negedge clk);
        chk("beat2 we", mem_we, 1);
        rst    = 1'b1;
        ls_req = 1'b0;
        @(negedge clk);
        chk("post rst we", mem_we, 0);
        chk("post rst ls_ack", ls_ack, 0);
        rst = 1'b0;
        mwe = 0;
        begin
            int acks = 0;
            repeat (6) begin
                @(negedge clk);
                acks += int'(ls_ack);
                mwe  += int'(mem_we);
            end
            chk("aborted ls_ack", acks, 0);
            chk("aborted mem_we", mwe, 0);
        end
        chk("partial bytes", {8'h0, mem[8'h83], mem[8'h81], mem[8'h80]}, 32'h0000F00D);
        if_addr = 32'h0;
        if_req  = 1'b1;
        lat     = 0;
        sb.push_back('{1'b0, 1'b1, 32'h00100513, 5});
        serve(1, 1'b0, 20);
        chk("scoreboard empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
